// File: rtl/stopwatch_lap_timer.sv
// MM:SS stopwatch with prescaled one-second tick, up/down counting, preset load
// and lap capture. Status encodes the controller state directly.
module stopwatch_lap_timer #(
    parameter int TICK_DIV = 1,
    parameter int MIN_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             reset,
    input  logic             lap,
    input  logic             mode,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [5:0]       load_sec,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic [MIN_W-1:0] lap_min,
    output logic [5:0]       lap_sec,
    output logic             lap_valid,
    output logic [1:0]       status,
    output logic             mode_q,
    output logic             event_p
);

    localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   P_LAST  = PW'(TICK_DIV - 1);
    localparam logic [MIN_W-1:0] MIN_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           state, state_n;
    logic [PW-1:0]    presc, presc_n;
    logic [MIN_W-1:0] min_n, lmin_n;
    logic [5:0]       sec_n, lsec_n, sec_clamped;
    logic             lv_n, mq_n, ev_n, time_zero;

    assign status      = state;
    assign sec_clamped = (load_sec > 6'd59) ? 6'd59 : load_sec;
    assign time_zero   = (minutes == '0) && (seconds == 6'd0);

    always_comb begin
        state_n = state;
        presc_n = presc;
        min_n   = minutes;
        sec_n   = seconds;
        lmin_n  = lap_min;
        lsec_n  = lap_sec;
        lv_n    = lap_valid;
        mq_n    = mode_q;
        ev_n    = 1'b0;

        if (reset) begin
            state_n = S_IDLE;
            presc_n = '0;
            min_n   = '0;
            sec_n   = 6'd0;
            lmin_n  = '0;
            lsec_n  = 6'd0;
            lv_n    = 1'b0;
            mq_n    = 1'b0;
        end else begin
            // Lap samples the pre-edge time, so any tick on this edge is not seen.
            if (lap && (state != S_IDLE)) begin
                lmin_n = minutes;
                lsec_n = seconds;
                lv_n   = 1'b1;
            end

            if (load && (state != S_RUN)) begin
                state_n = S_IDLE;
                presc_n = '0;
                min_n   = load_min;
                sec_n   = sec_clamped;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !stop && !(mode && time_zero)) begin
                            mq_n    = mode;
                            presc_n = '0;
                            state_n = S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            state_n = S_PAUSE;
                        end else if (presc != P_LAST) begin
                            presc_n = presc + 1'b1;
                        end else begin
                            presc_n = '0;
                            if (!mode_q) begin
                                if (seconds == 6'd59) begin
                                    sec_n = 6'd0;
                                    if (minutes == MIN_MAX) begin
                                        min_n = '0;
                                        ev_n  = 1'b1;
                                    end else begin
                                        min_n = minutes + 1'b1;
                                    end
                                end else begin
                                    sec_n = seconds + 1'b1;
                                end
                            end else begin
                                if (seconds == 6'd0) begin
                                    sec_n = 6'd59;
                                    min_n = minutes - 1'b1;
                                end else begin
                                    sec_n = seconds - 1'b1;
                                end
                                // The tick that lands on 00:00 finishes the countdown.
                                if ((minutes == '0) && (seconds == 6'd1)) begin
                                    ev_n    = 1'b1;
                                    state_n = S_DONE;
                                end
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (start && !stop) begin
                            state_n = S_RUN;
                        end
                    end
                    S_DONE: begin
                        state_n = S_DONE;
                    end
                    default: begin
                        state_n = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            presc     <= '0;
            minutes   <= '0;
            seconds   <= 6'd0;
            lap_min   <= '0;
            lap_sec   <= 6'd0;
            lap_valid <= 1'b0;
            mode_q    <= 1'b0;
            event_p   <= 1'b0;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            minutes   <= min_n;
            seconds   <= sec_n;
            lap_min   <= lmin_n;
            lap_sec   <= lsec_n;
            lap_valid <= lv_n;
            mode_q    <= mq_n;
            event_p   <= ev_n;
        end
    end

endmodule
